// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed byte image into instruction memory as
// big-endian 32-bit words and holds the CPU in reset until the image is in place.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000,
  parameter int          DEPTH     = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        WrEn,
  output logic [31:0] WrAddr,
  output logic [31:0] WrData,
  output logic        CpuRst,
  output logic        Done,
  output logic        Error
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  logic [2:0]  state, state_nxt;
  logic [15:0] n;
  logic [15:0] len;
  logic [10:0] widx;
  logic [10:0] widx_inc;
  logic [1:0]  bidx;
  logic        accept;

  assign accept   = ByteReady & ByteValid;
  assign len      = {n[15:8], ByteIn};
  assign widx_inc = widx + 11'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (Start) state_nxt = LEN_HI;
      LEN_HI: if (accept) state_nxt = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len == 16'd0)        state_nxt = DONE;
          else if (len > DEPTH_W)  state_nxt = ERR;
          else                     state_nxt = DATA;
        end
      end
      DATA:  if (accept && bidx == 2'd3) state_nxt = WRITE;
      WRITE: state_nxt = ({5'd0, widx_inc} == n) ? DONE : DATA;
      default: state_nxt = IDLE;
    endcase
  end

  // ByteReady and WrEn follow the next state so no byte is taken during WRITE;
  // status outputs follow the current state, giving Done one cycle after DONE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      ByteReady <= 1'b0;
      WrEn      <= 1'b0;
      WrAddr    <= BASE_ADDR;
      WrData    <= 32'd0;
      CpuRst    <= 1'b1;
      Done      <= 1'b0;
      Error     <= 1'b0;
      n         <= 16'd0;
      widx      <= 11'd0;
      bidx      <= 2'd0;
    end else begin
      state     <= state_nxt;
      ByteReady <= (state_nxt == LEN_HI) || (state_nxt == LEN_LO) || (state_nxt == DATA);
      WrEn      <= (state_nxt == WRITE);
      CpuRst    <= (state != DONE);
      Done      <= (state == DONE);
      Error     <= (state == ERR);

      case (state)
        LEN_HI: if (accept) n[15:8] <= ByteIn;
        LEN_LO: begin
          if (accept) begin
            n[7:0] <= ByteIn;
            widx   <= 11'd0;
            bidx   <= 2'd0;
          end
        end
        DATA: begin
          if (accept) begin
            case (bidx)
              2'd0: WrData[31:24] <= ByteIn;
              2'd1: WrData[23:16] <= ByteIn;
              2'd2: WrData[15:8]  <= ByteIn;
              default: WrData[7:0] <= ByteIn;
            endcase
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) WrAddr <= BASE_ADDR + {19'd0, widx, 2'b00};
          end
        end
        WRITE: begin
          widx <= widx_inc;
          bidx <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: one task per scenario, writes
// captured by a negedge monitor and compared with bench-computed expectations.
module tb_imem_loader;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  ByteIn = 8'd0;
  logic        ByteValid = 1'b0;
  logic        ByteReady;
  logic        WrEn;
  logic [31:0] WrAddr;
  logic [31:0] WrData;
  logic        CpuRst;
  logic        Done;
  logic        Error;

  int checks = 0;
  int errors = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  bit gaps = 1'b0;

  imem_loader dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .CpuRst(CpuRst), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (WrEn) begin
      log_addr.push_back(WrAddr);
      log_data.push_back(WrData);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    if (gaps) begin
      int g = $urandom_range(0, 1);
      repeat (g) begin @(posedge Clk); #1; end
    end
    ByteIn = b;
    ByteValid = 1'b1;
    @(negedge Clk);
    while (!ByteReady && k < 100) begin @(negedge Clk); k++; end
    if (!ByteReady) begin
      checks++; errors++;
      $display("FAIL send_byte timeout: ByteReady=%b required 1", ByteReady);
    end
    @(posedge Clk); #1;
    ByteValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({ByteReady, WrEn, CpuRst, Done, Error} !== 5'b00100 || WrAddr !== 32'h3000 || WrData !== 32'h0) begin
      errors++;
      $display("FAIL reset: rdy/wen/cpurst/done/err=%b addr=%h data=%h required 00100 3000 0",
               {ByteReady, WrEn, CpuRst, Done, Error}, WrAddr, WrData);
    end
    Rst = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_basic(input bit poke_start);
    log_addr.delete(); log_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    if (poke_start) Start = 1'b1;
    send_word(32'h3C010000);
    send_word(32'h34210005);
    // last byte taken at edge t; Start stays high through the WRITE cycle
    @(negedge Clk);
    checks++;
    if (WrEn !== 1'b1 || Done !== 1'b0) begin
      errors++; $display("FAIL basic_t0: WrEn=%b Done=%b required 1 0", WrEn, Done);
    end
    @(posedge Clk); #1;
    Start = 1'b0;
    @(negedge Clk);
    checks++;
    if (Done !== 1'b0 || CpuRst !== 1'b1) begin
      errors++; $display("FAIL basic_t1: Done=%b CpuRst=%b required 0 1", Done, CpuRst);
    end
    @(negedge Clk);
    checks++;
    if (Done !== 1'b1 || CpuRst !== 1'b0) begin
      errors++; $display("FAIL basic_t2: Done=%b CpuRst=%b required 1 0", Done, CpuRst);
    end
    checks++;
    if (log_addr.size() != 2) begin
      errors++; $display("FAIL basic_count: writes=%0d required 2", log_addr.size());
    end else begin
      checks++;
      if (log_addr[0] !== 32'h3000 || log_data[0] !== 32'h3C010000) begin
        errors++; $display("FAIL basic_w0: %h/%h required 00003000/3c010000", log_addr[0], log_data[0]);
      end
      checks++;
      if (log_addr[1] !== 32'h3004 || log_data[1] !== 32'h34210005) begin
        errors++; $display("FAIL basic_w1: %h/%h required 00003004/34210005", log_addr[1], log_data[1]);
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_zero_len();
    log_addr.delete(); log_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (Done !== 1'b1 || CpuRst !== 1'b0 || log_addr.size() != 0) begin
      errors++;
      $display("FAIL zero_len: Done=%b CpuRst=%b writes=%0d required 1 0 0", Done, CpuRst, log_addr.size());
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_error();
    log_addr.delete(); log_data.delete();
    pulse_start();
    send_byte(8'h04); send_byte(8'h01);
    repeat (3) @(negedge Clk);
    checks++;
    if (Error !== 1'b1 || CpuRst !== 1'b1 || ByteReady !== 1'b0 || Done !== 1'b0 || log_addr.size() != 0) begin
      errors++;
      $display("FAIL error_state: Error=%b CpuRst=%b ByteReady=%b Done=%b writes=%0d required 1 1 0 0 0",
               Error, CpuRst, ByteReady, Done, log_addr.size());
    end
    @(posedge Clk); #1;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'hAABBCCDD);
    repeat (3) @(negedge Clk);
    checks++;
    if (Error !== 1'b0 || Done !== 1'b1) begin
      errors++; $display("FAIL error_recover: Error=%b Done=%b required 0 1", Error, Done);
    end
    checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h3000 || log_data[0] !== 32'hAABBCCDD) begin
      errors++; $display("FAIL error_write: writes=%0d required single 00003000/aabbccdd", log_addr.size());
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_gaps();
    int bad = 0;
    log_addr.delete(); log_data.delete();
    gaps = 1'b1;
    pulse_start();
    send_byte(8'h04); send_byte(8'h00);
    for (int i = 0; i < 1024; i++) send_word((i * 32'h9E3779B1) ^ 32'h0F0F0F0F);
    gaps = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (log_addr.size() != 1024 || Done !== 1'b1) begin
      errors++; $display("FAIL gaps_count: writes=%0d Done=%b required 1024 1", log_addr.size(), Done);
    end else begin
      for (int i = 0; i < 1024; i++) begin
        logic [31:0] ea;
        logic [31:0] ed;
        ea = 32'h3000 + 32'(i) * 4;
        ed = (i * 32'h9E3779B1) ^ 32'h0F0F0F0F;
        if (log_addr[i] !== ea || log_data[i] !== ed) begin
          if (bad < 5)
            $display("FAIL gaps_word%0d: %h/%h required %h/%h", i, log_addr[i], log_data[i], ea, ed);
          bad++;
        end
      end
      checks++;
      if (bad != 0) errors++;
      checks++;
      if (log_addr[1023] !== 32'h3FFC) begin
        errors++; $display("FAIL gaps_last: addr=%h required 00003ffc", log_addr[1023]);
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_rst_mid();
    log_addr.delete(); log_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h0A);
    for (int i = 0; i < 6; i++) send_word(32'h11110000 + i);
    send_byte(8'hEE); send_byte(8'hFF);
    #2 Rst = 1'b1;
    #1;
    checks++;
    if ({ByteReady, WrEn, CpuRst, Done, Error} !== 5'b00100 || WrAddr !== 32'h3000 || WrData !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: rdy/wen/cpurst/done/err=%b addr=%h data=%h required 00100 3000 0",
               {ByteReady, WrEn, CpuRst, Done, Error}, WrAddr, WrData);
    end
    checks++;
    if (log_addr.size() != 6 || log_addr[5] !== 32'h3014 || log_data[5] !== 32'h11110005) begin
      errors++; $display("FAIL rst_prior: writes=%0d required 6 ending 00003014/11110005", log_addr.size());
    end
    ByteValid = 1'b1; ByteIn = 8'h55;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    repeat (10) @(posedge Clk);
    #1 ByteValid = 1'b0;
    checks++;
    if (log_addr.size() != 6 || ByteReady !== 1'b0) begin
      errors++; $display("FAIL rst_quiet: writes=%0d ByteReady=%b required 6 0", log_addr.size(), ByteReady);
    end
    log_addr.delete(); log_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_word(32'hDEADBEEF);
    repeat (3) @(negedge Clk);
    checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h3000 || log_data[0] !== 32'hDEADBEEF || Done !== 1'b1) begin
      errors++; $display("FAIL rst_reload: writes=%0d Done=%b required 1 write 00003000/deadbeef, Done 1",
                         log_addr.size(), Done);
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_zero_len();
    test_error();
    test_gaps();
    test_rst_mid();
    test_basic(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
